// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Brief    : Architectural register file x0..x31 with per-register rename
//            tags. Retires in-order commits, records destination renames,
//            serves combinational operand lookups (tag or value) and clears
//            every pending rename on a misprediction flush.
//            Optional macro RF_COMMIT_BYPASS_EN forwards a same-cycle commit
//            to the lookup ports.
// Revision : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int                  REG_WIDTH    = 5,
  parameter int                  EX_REG_WIDTH = 6,
  parameter logic [5:0]          NON_REG      = 6'b100000,
  parameter int                  RoB_WIDTH    = 8,
  parameter int                  EX_RoB_WIDTH = 9,
  parameter logic [8:0]          NON_DEP      = 9'b100000000
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst_n,
  input  logic                    Sys_rdy,
  input  logic [REG_WIDTH-1:0]    DPRF_rs1,
  input  logic [REG_WIDTH-1:0]    DPRF_rs2,
  output logic [EX_RoB_WIDTH-1:0] RFDP_Qj,
  output logic [EX_RoB_WIDTH-1:0] RFDP_Qk,
  output logic [31:0]             RFDP_Vj,
  output logic [31:0]             RFDP_Vk,
  input  logic                    DPRF_en,
  input  logic [EX_REG_WIDTH-1:0] DPRF_rd,
  input  logic [RoB_WIDTH-1:0]    DPRF_RoB_index,
  input  logic                    RoBRF_pre_judge,
  input  logic                    RoBRF_en,
  input  logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  input  logic [EX_REG_WIDTH-1:0] RoBRF_rd,
  input  logic [31:0]             RoBRF_value
);

  localparam int NUM_REGS   = 1 << REG_WIDTH;
  localparam int DATA_WIDTH = 32;

  logic [DATA_WIDTH-1:0]   value_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   value_d [NUM_REGS];
  logic [EX_RoB_WIDTH-1:0] tag_q   [NUM_REGS];
  logic [EX_RoB_WIDTH-1:0] tag_d   [NUM_REGS];

  logic                    commit_valid;
  logic                    rename_valid;
  logic [REG_WIDTH-1:0]    commit_idx;
  logic [REG_WIDTH-1:0]    rename_idx;
  logic [EX_RoB_WIDTH-1:0] commit_tag;

  // x0 and the no-register marker are never real write targets
  assign commit_idx   = RoBRF_rd[REG_WIDTH-1:0];
  assign rename_idx   = DPRF_rd[REG_WIDTH-1:0];
  assign commit_tag   = {1'b0, RoBRF_RoB_index};
  assign commit_valid = RoBRF_en && (RoBRF_rd != NON_REG) && (commit_idx != '0);
  assign rename_valid = DPRF_en && (DPRF_rd != NON_REG) && (rename_idx != '0);

  // Next state: commit value write, tag clear, then flush or rename on tags
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    if (Sys_rdy) begin
      if (commit_valid) begin
        value_d[commit_idx] = RoBRF_value;
        // Only the producer that still owns the register releases it
        if (tag_q[commit_idx] == commit_tag) begin
          tag_d[commit_idx] = NON_DEP;
        end
      end
      if (!RoBRF_pre_judge) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          tag_d[i] = NON_DEP;
        end
      end else if (rename_valid) begin
        // A rename overrides the clear from a same-cycle commit
        tag_d[rename_idx] = {1'b0, DPRF_RoB_index};
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= NON_DEP;
      end
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  // Operand lookup: {tag, value}; value is only exposed when no producer pends
  function automatic logic [EX_RoB_WIDTH+DATA_WIDTH-1:0] lookup(
    input logic [REG_WIDTH-1:0] src
  );
    logic [EX_RoB_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0]   v;
    q = NON_DEP;
    v = '0;
    if (src != '0) begin
      if (tag_q[src] == NON_DEP) begin
        v = value_q[src];
      end else begin
        q = tag_q[src];
      end
`ifdef RF_COMMIT_BYPASS_EN
      // Forward the value of the owning producer committing right now
      if (Sys_rdy && commit_valid && (commit_idx == src) && (tag_q[src] == commit_tag)) begin
        q = NON_DEP;
        v = RoBRF_value;
      end
`endif
    end
    return {q, v};
  endfunction

  assign {RFDP_Qj, RFDP_Vj} = lookup(DPRF_rs1);
  assign {RFDP_Qk, RFDP_Vk} = lookup(DPRF_rs2);

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Brief    : Scoreboard bench for register_file. Stimulus pushes expected
//            lookup results into a queue; a monitor pops and compares at the
//            falling edge whenever a lookup is flagged valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file;

  localparam logic [8:0] NON_DEP = 9'b100000000;
  localparam logic [5:0] NON_REG = 6'b100000;

  typedef struct {
    string       name;
    logic [8:0]  qj;
    logic [31:0] vj;
    logic [8:0]  qk;
    logic [31:0] vk;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [4:0]  rs1, rs2;
  logic [8:0]  qj, qk;
  logic [31:0] vj, vk;
  logic        dp_en;
  logic [5:0]  dp_rd;
  logic [7:0]  dp_idx;
  logic        pre_judge;
  logic        cm_en;
  logic [7:0]  cm_idx;
  logic [5:0]  cm_rd;
  logic [31:0] cm_val;
  logic        lookup_vld;

  exp_t sb[$];
  int   total;
  int   bad;

  register_file dut (
    .Sys_clk        (clk),
    .Sys_rst_n      (rst_n),
    .Sys_rdy        (rdy),
    .DPRF_rs1       (rs1),
    .DPRF_rs2       (rs2),
    .RFDP_Qj        (qj),
    .RFDP_Qk        (qk),
    .RFDP_Vj        (vj),
    .RFDP_Vk        (vk),
    .DPRF_en        (dp_en),
    .DPRF_rd        (dp_rd),
    .DPRF_RoB_index (dp_idx),
    .RoBRF_pre_judge(pre_judge),
    .RoBRF_en       (cm_en),
    .RoBRF_RoB_index(cm_idx),
    .RoBRF_rd       (cm_rd),
    .RoBRF_value    (cm_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Monitor: pops expected lookup result and compares both ports
  always @(negedge clk) begin
    if (lookup_vld) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow: lookup presented with no expectation");
      end else begin
        exp_t e;
        e = sb.pop_front();
        total++;
        if (qj !== e.qj || vj !== e.vj) begin
          bad++;
          $display("FAIL %s port_j: got Q=%h V=%h expected Q=%h V=%h", e.name, qj, vj, e.qj, e.vj);
        end
        total++;
        if (qk !== e.qk || vk !== e.vk) begin
          bad++;
          $display("FAIL %s port_k: got Q=%h V=%h expected Q=%h V=%h", e.name, qk, vk, e.qk, e.vk);
        end
      end
    end
  end

  task automatic idle();
    rdy = 1'b1; pre_judge = 1'b1;
    dp_en = 1'b0; dp_rd = '0; dp_idx = '0;
    cm_en = 1'b0; cm_idx = '0; cm_rd = '0; cm_val = '0;
    rs1 = '0; rs2 = '0; lookup_vld = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic look(input string name, input logic [4:0] a, input logic [4:0] b,
                      input logic [8:0] eqj, input logic [31:0] evj,
                      input logic [8:0] eqk, input logic [31:0] evk);
    exp_t e;
    rs1 = a; rs2 = b; lookup_vld = 1'b1;
    e.name = name; e.qj = eqj; e.vj = evj; e.qk = eqk; e.vk = evk;
    sb.push_back(e);
  endtask

  task automatic rename(input logic [5:0] rd, input logic [7:0] idx);
    dp_en = 1'b1; dp_rd = rd; dp_idx = idx;
  endtask

  task automatic commit(input logic [7:0] idx, input logic [5:0] rd, input logic [31:0] val);
    cm_en = 1'b1; cm_idx = idx; cm_rd = rd; cm_val = val;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset state
    look("reset_x5_x0", 5'd5, 5'd0, NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();

    // Rename x3 -> 7; source read sees the old state in the same cycle
    rename(6'd3, 8'd7);
    look("rename_same_cycle", 5'd3, 5'd0, NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();
    look("rename_x3", 5'd3, 5'd0, 9'd7, 32'h0, NON_DEP, 32'h0);
    tick();

    // Commit index 7 to x3
    commit(8'd7, 6'd3, 32'hDEADBEEF);
`ifdef RF_COMMIT_BYPASS_EN
    look("commit_cycle_x3", 5'd3, 5'd0, NON_DEP, 32'hDEADBEEF, NON_DEP, 32'h0);
`else
    look("commit_cycle_x3", 5'd3, 5'd0, 9'd7, 32'h0, NON_DEP, 32'h0);
`endif
    tick();
    look("after_commit_x3", 5'd3, 5'd3, NON_DEP, 32'hDEADBEEF, NON_DEP, 32'hDEADBEEF);
    tick();

    // Older commit does not clear a younger rename
    rename(6'd4, 8'd2); tick();
    rename(6'd4, 8'd9); tick();
    commit(8'd2, 6'd4, 32'h11);
    look("stale_commit_cycle", 5'd0, 5'd4, NON_DEP, 32'h0, 9'd9, 32'h0);
    tick();
    look("stale_commit_x4", 5'd4, 5'd0, 9'd9, 32'h0, NON_DEP, 32'h0);
    tick();

    // Same-cycle commit and rename of x6: rename wins the tag
    rename(6'd6, 8'd5); tick();
    commit(8'd5, 6'd6, 32'h22);
    rename(6'd6, 8'd12);
`ifdef RF_COMMIT_BYPASS_EN
    look("commit_rename_cycle", 5'd6, 5'd0, NON_DEP, 32'h22, NON_DEP, 32'h0);
`else
    look("commit_rename_cycle", 5'd6, 5'd0, 9'd5, 32'h0, NON_DEP, 32'h0);
`endif
    tick();
    look("commit_rename_x6", 5'd6, 5'd0, 9'd12, 32'h0, NON_DEP, 32'h0);
    tick();

    // Pending tags on x1, x2, x10
    rename(6'd1, 8'd20); tick();
    rename(6'd2, 8'd21); tick();
    rename(6'd10, 8'd22);
    look("pending_x1_x2", 5'd1, 5'd2, 9'd20, 32'h0, 9'd21, 32'h0);
    tick();

    // Flush with a commit of x10 and a dropped rename of x8
    pre_judge = 1'b0;
    rename(6'd8, 8'd30);
    commit(8'd22, 6'd10, 32'h55);
`ifdef RF_COMMIT_BYPASS_EN
    look("flush_cycle_x10", 5'd10, 5'd8, NON_DEP, 32'h55, NON_DEP, 32'h0);
`else
    look("flush_cycle_x10", 5'd10, 5'd8, 9'd22, 32'h0, NON_DEP, 32'h0);
`endif
    tick();
    look("flush_x1_x2", 5'd1, 5'd2, NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();
    look("flush_x10_x8", 5'd10, 5'd8, NON_DEP, 32'h55, NON_DEP, 32'h0);
    tick();
    look("flush_x4_x6", 5'd4, 5'd6, NON_DEP, 32'h11, NON_DEP, 32'h22);
    tick();

    // x0 and NON_REG targets are ignored
    commit(8'd1, 6'd0, 32'h5);
    rename(NON_REG, 8'd3);
    tick();
    rename(6'd0, 8'd4);
    tick();
    look("x0_x1", 5'd0, 5'd1, NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();

    // Held cycle: no commit, rename, or flush takes effect
    rename(6'd12, 8'd60); tick();
    rdy = 1'b0;
    commit(8'd0, 6'd5, 32'h77);
    rename(6'd7, 8'd50);
    tick();
    rdy = 1'b0;
    pre_judge = 1'b0;
    tick();
    look("hold_x5_x7", 5'd5, 5'd7, NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();
    look("hold_x12", 5'd12, 5'd3, 9'd60, 32'h0, NON_DEP, 32'hDEADBEEF);
    tick();

    // Reset mid-operation wipes tags and values
    rst_n = 1'b0;
    commit(8'd60, 6'd12, 32'h99);
    tick();
    rst_n = 1'b1;
    look("reset_mid_x12_x3", 5'd12, 5'd3, NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();

    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file.md
# register_file

Architectural register file with per-register rename tags for the Tomasulo core. It receives in-order commits from the reorder buffer (`RoBRF_*`) and retires their values into `x1..x31`. It takes destination renames from the dispatcher and answers the dispatcher's combinational operand lookups (tag or value). On a misprediction flush it discards all outstanding renames.

## Interface
- `REG_WIDTH`, 5: architectural register index width.
- `EX_REG_WIDTH`, 6: destination width including the no-register flag.
- `NON_REG`, 6'b100000: "no destination register".
- `RoB_WIDTH`, 8: RoB index width.
- `EX_RoB_WIDTH`, 9: tag width including the no-dependency flag.
- `NON_DEP`, 9'b100000000: "value is architectural, no pending producer".

- `Sys_clk`  in  1  sole clock; all state updates on rising edge.
- `Sys_rst_n`  in  1  synchronous, active-low reset.
- `Sys_rdy`  in  1  global enable; when 0, no state changes.
- `DPRF_rs1`, `DPRF_rs2`  in  5 each  source register lookups.
- `RFDP_Qj`, `RFDP_Qk`  out  9 each  producer tag for rs1/rs2, or `NON_DEP`.
- `RFDP_Vj`, `RFDP_Vk`  out  32 each  register value; valid when the tag is `NON_DEP`, otherwise 0.
- `DPRF_en`  in  1  rename request this cycle.
- `DPRF_rd`  in  6  destination of the renamed instruction (`NON_REG` allowed).
- `DPRF_RoB_index`  in  8  RoB slot of the renamed instruction.
- `RoBRF_pre_judge`  in  1  0 = misprediction flush this cycle.
- `RoBRF_en`  in  1  commit valid.
- `RoBRF_RoB_index`  in  8  RoB slot being committed.
- `RoBRF_rd`  in  6  committed destination.
- `RoBRF_value`  in  32  committed value.

## Operation
- State: `value[0..31]` (32 b each) and `tag[0..31]` (9 b each). `x0` has no storage semantics: reads always return 0 with `NON_DEP`, and writes and renames to it are ignored.
- A destination is a write target only if `rd != NON_REG` and `rd[4:0] != 0`.
- Commit, when `RoBRF_en` is set and the target is valid:
  - `value[rd] <= RoBRF_value`.
  - If `tag[rd] == {0, RoBRF_RoB_index}`, then `tag[rd] <= NON_DEP`. Otherwise the tag is kept, because a younger renamer owns the register.
- Rename, when `DPRF_en` is set, the target is valid and `RoBRF_pre_judge == 1`: `tag[rd] <= {0, DPRF_RoB_index}`.
- Same-cycle commit and rename of the same rd:
  - The value is written.
  - The tag takes the new rename, so rename has priority over the tag clear.
- Flush (`RoBRF_pre_judge == 0` with `Sys_rdy`):
  - All tags go to `NON_DEP`.
  - A commit in the same cycle still writes its value, because the committing instruction is older than the branch.
  - Any rename in that cycle is dropped.
- Operand lookup is combinational from current state. Sources are read before the same instruction's own rename, so `addi x1,x1,1` gets the previous tag of x1, not its own.
- Priority: reset > `!Sys_rdy` (hold) > flush > commit/rename.

## Timing
- Reset (`Sys_rst_n == 0` at an edge): all `value` = 0, all `tag` = `NON_DEP`. After reset, outputs are `RFDP_Qj` = `RFDP_Qk` = `NON_DEP` and `RFDP_Vj` = `RFDP_Vk` = 0.
- Reset mid-operation discards all pending tags in the same edge.
- Lookup latency is 0 cycles, purely combinational.
- Commit and rename become visible to lookups the cycle after the edge. The exception is the bypass described under Configuration.
- There is no handshake or backpressure: every asserted `RoBRF_en` and `DPRF_en` with `Sys_rdy` high is consumed in that cycle.
- Tag compare uses all 8 RoB index bits with the flag bit = 0. Wrap of RoB indices needs no special handling.

## Configuration
- `RF_COMMIT_BYPASS_EN` defined:
  - If a lookup's source equals a valid `RoBRF_rd` committing this cycle and `tag[src] == {0, RoBRF_RoB_index}`, the output is `NON_DEP` with `RoBRF_value`.
  - This bypass applies during flush cycles too.
- Undefined: lookups reflect registered state only, so the dispatcher sees the commit one cycle later.

## Test plan
- Reset, then look up rs1 = 5 and rs2 = 0 → `Qj` = `NON_DEP`, `Vj` = 0, `Qk` = `NON_DEP`, `Vk` = 0.
- Rename x3 to index 7, then the next cycle look up x3 → `Qj` = 7. Commit index 7 with rd = 3 and value 0xDEADBEEF → the next cycle gives `Qj` = `NON_DEP`, `Vj` = 0xDEADBEEF. With `RF_COMMIT_BYPASS_EN`, the lookup in the commit cycle already returns that result.
- Rename x4 to 2, then rename x4 to 9, then commit index 2 rd 4 value 0x11 → tag stays 9 and `value[4]` = 0x11.
- Same cycle: commit index 5 rd 6 value 0x22 while renaming rd 6 to index 12 → afterwards `tag[6]` = 12 and `value[6]` = 0x22.
- Tags pending on x1, x2 and x10, then flush with `RoBRF_pre_judge` = 0 plus a simultaneous rename of x8 → all tags = `NON_DEP`, values unchanged, x8 not renamed.
- Commit rd 0 value 5, rename rd `NON_REG`, and toggle `Sys_rdy` = 0 during a commit → x0 reads 0, no tag changes, and the held cycle causes no update.
